// File: rtl/stopwatch_timebase.sv
// rtl/stopwatch_timebase.sv - stopwatch master time base: button sync, run/pause FSM, sub-ms counter
// Feeds time_ns/ms_tick to the ms digit flop and pulses digit_clear to zero the digit chain.
module stopwatch_timebase #(
   parameter int                    COUNT_SIZE = 20,
   parameter logic [COUNT_SIZE-1:0] COUNT_MAX  = COUNT_SIZE'(999999)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_btn,
   input  logic                  clear_btn,
   output logic [COUNT_SIZE-1:0] time_ns,
   output logic                  ms_tick,
   output logic                  running,
   output logic                  digit_clear
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] start_sync;
   logic [1:0] clear_sync;
   logic       start_d;
   logic       clear_d;
   logic       start_press;
   logic       clear_press;

   // Two-flop synchronisers plus a delay flop so a held button yields one press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_sync <= 2'b00;
         clear_sync <= 2'b00;
         start_d    <= 1'b0;
         clear_d    <= 1'b0;
      end else begin
         start_sync <= {start_sync[0], start_btn};
         clear_sync <= {clear_sync[0], clear_btn};
         start_d    <= start_sync[1];
         clear_d    <= clear_sync[1];
      end
   end

   assign start_press = start_sync[1] & ~start_d;
   assign clear_press = clear_sync[1] & ~clear_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Clear outranks start: a simultaneous start press is simply dropped.
   always_comb begin
      state_next = state;
      if (clear_press) begin
         state_next = IDLE;
      end else if (start_press) begin
         case (state)
            IDLE:    state_next = RUNNING;
            RUNNING: state_next = PAUSED;
            PAUSED:  state_next = RUNNING;
            default: state_next = IDLE;
         endcase
      end
   end

   // Counting keys off the registered state, so the first increment lands one edge after entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         time_ns     <= '0;
         digit_clear <= 1'b0;
      end else begin
         digit_clear <= clear_press;
         if (clear_press) begin
            time_ns <= '0;
         end else if (state == RUNNING) begin
            time_ns <= (time_ns == COUNT_MAX) ? '0 : time_ns + COUNT_SIZE'(1);
         end
      end
   end

   assign running = (state == RUNNING);
   assign ms_tick = running & (time_ns == COUNT_MAX);

endmodule

// File: tb/tb_stopwatch_timebase.sv
// tb/tb_stopwatch_timebase.sv - directed self-checking bench for stopwatch_timebase
// Uses a short terminal count of 9 so wrap and tick behaviour show up within a few cycles.
module tb_stopwatch_timebase;

   localparam int COUNT_SIZE = 20;

   logic                  clk;
   logic                  rst;
   logic                  start_btn;
   logic                  clear_btn;
   logic [COUNT_SIZE-1:0] time_ns;
   logic                  ms_tick;
   logic                  running;
   logic                  digit_clear;

   int checks;
   int errors;
   int tick_count;

   stopwatch_timebase #(
      .COUNT_SIZE (COUNT_SIZE),
      .COUNT_MAX  (20'd9)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_btn   (start_btn),
      .clear_btn   (clear_btn),
      .time_ns     (time_ns),
      .ms_tick     (ms_tick),
      .running     (running),
      .digit_clear (digit_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int t, input bit run, input bit tk, input bit dc);
      chk({tag, ".time_ns"}, 32'(time_ns), 32'(t));
      chk({tag, ".running"}, 32'(running), 32'(run));
      chk({tag, ".ms_tick"}, 32'(ms_tick), 32'(tk));
      chk({tag, ".digit_clear"}, 32'(digit_clear), 32'(dc));
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      tick_count = 0;
      rst        = 1'b0;
      start_btn  = 1'b0;
      clear_btn  = 1'b0;

      // Reset held while buttons toggle: everything stays at reset values.
      for (int i = 0; i < 8; i++) begin
         start_btn = i[0];
         clear_btn = i[1];
         tick();
         chk_all("reset_hold", 0, 0, 0, 0);
      end
      start_btn = 1'b0;
      clear_btn = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk_all("after_release", 0, 0, 0, 0);

      // Start: FSM acts at edge k+2, first increment at k+3.
      start_btn = 1'b1;
      tick();
      chk("start_k.running", 32'(running), 0);
      tick();
      chk("start_k1.running", 32'(running), 0);
      tick();
      chk_all("start_k2", 0, 1, 0, 0);
      start_btn = 1'b0;
      tick();
      chk_all("start_k3", 1, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_all("count", (2 + i) % 10, 1, ((2 + i) % 10) == 9, 0);
         if (ms_tick) tick_count++;
      end
      chk("tick_count", 32'(tick_count), 2);

      // Pause lands at 4: the three press edges still count 1->2->3->4.
      start_btn = 1'b1;
      tick();
      tick();
      tick();
      start_btn = 1'b0;
      chk_all("pause_at4", 4, 0, 0, 0);
      for (int i = 0; i < 50; i++) begin
         tick();
         chk_all("paused4", 4, 0, 0, 0);
      end
      start_btn = 1'b1;
      tick();
      tick();
      tick();
      start_btn = 1'b0;
      chk_all("resume", 4, 1, 0, 0);
      tick();
      chk_all("resume_5", 5, 1, 0, 0);
      tick();
      chk_all("resume_6", 6, 1, 0, 0);

      // Pause exactly at the terminal count: no ms_tick while paused.
      start_btn = 1'b1;
      tick();
      tick();
      tick();
      start_btn = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_all("paused9", 9, 0, 0, 0);
      end
      start_btn = 1'b1;
      tick();
      tick();
      tick();
      start_btn = 1'b0;
      chk_all("resume9", 9, 1, 1, 0);
      tick();
      chk_all("wrap0", 0, 1, 0, 0);

      // Clear and start together at time_ns=7: clear wins.
      for (int i = 0; i < 5; i++) tick();
      chk_all("pre_clear", 5, 1, 0, 0);
      start_btn = 1'b1;
      clear_btn = 1'b1;
      tick();
      chk_all("both_k", 6, 1, 0, 0);
      tick();
      chk_all("both_k1", 7, 1, 0, 0);
      tick();
      chk_all("both_k2", 0, 0, 0, 1);
      tick();
      chk_all("both_k3", 0, 0, 0, 0);
      start_btn = 1'b0;
      clear_btn = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk_all("both_after", 0, 0, 0, 0);

      // Clear in IDLE still pulses digit_clear for one cycle.
      clear_btn = 1'b1;
      tick();
      tick();
      tick();
      chk_all("idle_clear", 0, 0, 0, 1);
      tick();
      chk_all("idle_clear_end", 0, 0, 0, 0);
      clear_btn = 1'b0;
      tick();

      // Held start for 100 cycles: a single IDLE->RUNNING transition.
      start_btn = 1'b1;
      tick();
      tick();
      tick();
      chk_all("held_enter", 0, 1, 0, 0);
      for (int i = 0; i < 97; i++) tick();
      chk_all("held_100", 7, 1, 0, 0);
      start_btn = 1'b0;
      tick();
      chk_all("held_release", 8, 1, 0, 0);

      // Asynchronous reset mid-count acts before the next edge.
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk_all("async_reset", 0, 0, 0, 0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk_all("post_async", 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
